// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: word width, fetch constants and the IF/ID
// register layout that the decode stage also consumes.
package fetch_stage_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] RESET_PC  = 32'd0;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'd0;
  localparam logic [WORD_WIDTH-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instruction;
    logic                  valid;
  } if_id_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard/branch controls, instruction-memory port and
// the IF/ID register outputs toward decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                  freeze;
  logic                  branch_taken;
  logic [WORD_WIDTH-1:0] branch_addr;
  logic [WORD_WIDTH-1:0] instruction_in;
  logic [WORD_WIDTH-1:0] pc_out;
  logic [WORD_WIDTH-1:0] if_id_pc;
  logic [WORD_WIDTH-1:0] if_id_instruction;
  logic                  if_id_valid;

  modport master (
    input  freeze, branch_taken, branch_addr, instruction_in,
    output pc_out, if_id_pc, if_id_instruction, if_id_valid
  );

  modport slave (
    output freeze, branch_taken, branch_addr, instruction_in,
    input  pc_out, if_id_pc, if_id_instruction, if_id_valid
  );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: synchronous reset, redirect load, hold, and sequential
// advance by PC_STEP (modulo 2^32).
module pc_register #(
  parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = fetch_stage_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_addr,
  output logic [31:0] pc
);
  import fetch_stage_pkg::*;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= word_align(load_addr);
    end else if (!hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: drives the PC to instruction memory and
// captures the returned word into the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR,
  parameter logic [31:0] PC_STEP   = fetch_stage_pkg::PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  import fetch_stage_pkg::*;

  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] pc_seq;
  if_id_t                if_id_q;

  // A taken branch overrides freeze, so the PC only holds when not redirecting.
  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .hold      (bus.freeze),
    .load      (bus.branch_taken),
    .load_addr (bus.branch_addr),
    .pc        (pc)
  );

  assign pc_seq = pc + PC_STEP;

  // NOTE: the whole IF/ID register is reset to a bubble so decode never sees
  // stale contents as a valid instruction.
  always_ff @(posedge clk) begin
    if (rst || bus.branch_taken) begin
      if_id_q <= '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};
    end else if (!bus.freeze) begin
      if_id_q <= '{pc: pc_seq, instruction: bus.instruction_in, valid: 1'b1};
    end
  end

  assign bus.pc_out            = pc;
  assign bus.if_id_pc          = if_id_q.pc;
  assign bus.if_id_instruction = if_id_q.instruction;
  assign bus.if_id_valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returns 32'h1000_0000 + address.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.instruction_in = 32'h1000_0000 + bus.pc_out;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] id_pc,
                           input logic [31:0] id_instr, input logic id_valid);
    check({tag, ".pc_out"}, bus.pc_out, pc);
    check({tag, ".if_id_pc"}, bus.if_id_pc, id_pc);
    check({tag, ".if_id_instr"}, bus.if_id_instruction, id_instr);
    check({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid}, {31'd0, id_valid});
  endtask

  initial begin
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = 32'd0;
    step();
    step();
    check_all("reset", 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    // Free-running fetch
    step(); check_all("seq1", 32'd4, 32'd4, 32'h1000_0000, 1'b1);
    step(); check_all("seq2", 32'd8, 32'd8, 32'h1000_0004, 1'b1);

    // Freeze for three cycles at pc_out=8
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("freeze", 32'd8, 32'd8, 32'h1000_0004, 1'b1);
    end
    bus.freeze = 1'b0;
    step(); check_all("resume", 32'd12, 32'd12, 32'h1000_0008, 1'b1);
    step(); check_all("seq3", 32'd16, 32'd16, 32'h1000_000C, 1'b1);

    // Branch redirect at pc_out=16
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h40;
    step(); check_all("branch", 32'h40, 32'd0, 32'd0, 1'b0);
    bus.branch_taken = 1'b0;
    step(); check_all("post_branch", 32'h44, 32'h44, 32'h1000_0040, 1'b1);

    // Branch with freeze, unaligned target
    bus.branch_taken = 1'b1;
    bus.freeze = 1'b1;
    bus.branch_addr = 32'h23;
    step(); check_all("branch_freeze", 32'h20, 32'd0, 32'd0, 1'b0);

    // Back-to-back branch keeps flushing
    bus.freeze = 1'b0;
    bus.branch_addr = 32'h100;
    step(); check_all("branch_again", 32'h100, 32'd0, 32'd0, 1'b0);
    bus.branch_taken = 1'b0;
    step(); check_all("post_branch2", 32'h104, 32'h104, 32'h1000_0100, 1'b1);

    // Reset overrides freeze and branch
    bus.freeze = 1'b1;
    step(); check_all("freeze2", 32'h104, 32'h104, 32'h1000_0100, 1'b1);
    rst = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h80;
    step(); check_all("reset_mid", 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    bus.freeze = 1'b0;

    // PC wrap-around
    bus.branch_addr = 32'hFFFF_FFFF;
    step(); check_all("load_top", 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0);
    bus.branch_taken = 1'b0;
    step(); check_all("wrap", 32'd0, 32'd0, 32'h0FFF_FFFC, 1'b1);
    step(); check_all("after_wrap", 32'd4, 32'd4, 32'h1000_0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter and drives the instruction-memory address each cycle. It captures the returned instruction into the IF/ID pipeline register and handles freeze (hazard stall), branch redirect and flush. It sits directly upstream of the combinational instruction memory and feeds the decode stage.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
NOP_INSTR, 32'd0, instruction word inserted into IF/ID on flush/reset (bubble)
PC_STEP, 32'd4, sequential PC increment in bytes

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
freeze  input  1  hazard stall from hazard unit; hold PC and IF/ID
branch_taken  input  1  branch/jump resolved taken; redirect PC and flush IF/ID
branch_addr  input  32  byte target address for the redirect
instruction_in  input  32  instruction word returned combinationally by instruction memory for pc_out
pc_out  output  32  current PC, drives instruction-memory Address
if_id_pc  output  32  registered PC+PC_STEP of the fetched instruction, to ID
if_id_instruction  output  32  registered instruction, to ID
if_id_valid  output  1  1 = if_id_instruction is a real fetched instruction, 0 = bubble

Behaviour:
- Reset is synchronous and active-high; one clock (clk); no other reset or clock.
- Reset (rst=1 at rising edge): pc <= RESET_PC; if_id_pc <= 0; if_id_instruction <= NOP_INSTR; if_id_valid <= 0. Reset overrides all other inputs, including mid-stall and mid-redirect.
- pc_out = pc register (no combinational path from inputs to pc_out).
- Per-edge priority when rst=0: branch_taken > freeze > normal.
- Normal (branch_taken=0, freeze=0):
  - pc <= pc + PC_STEP.
  - if_id_pc <= pc + PC_STEP.
  - if_id_instruction <= instruction_in.
  - if_id_valid <= 1.
- Freeze (branch_taken=0, freeze=1): pc, if_id_pc, if_id_instruction and if_id_valid all hold. Freeze may last any number of cycles; the fetch sequence resumes unchanged.
- Branch (branch_taken=1, regardless of freeze):
  - pc <= {branch_addr[31:2], 2'b00}; the low two bits are forced to zero.
  - IF/ID is flushed: if_id_instruction <= NOP_INSTR, if_id_valid <= 0, if_id_pc <= 0.
  - The instruction fetched in that cycle is discarded.
- Latency: an instruction at address A appears on if_id_* one edge after pc_out=A (1-cycle fetch).
- Wrap-around: pc + PC_STEP is modulo 2^32; 32'hFFFFFFFC advances to 0 with no flag.
- branch_taken held for consecutive cycles: each edge re-redirects and re-flushes; if_id_valid stays 0.
- Adding PC_STEP is the only arithmetic; the adder is 32-bit with carry-out dropped.

Decomposition:
- Shared pipeline package holds:
  - WORD_WIDTH=32.
  - NOP_INSTR constant.
  - RESET_PC constant.
  - An IF/ID struct typedef {pc[31:0], instruction[31:0], valid} reused by decode.
- One natural sub-module: pc_register, which holds the PC with synchronous reset, hold enable and load-mux. The IF/ID register stays inline in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, memory model returning 32'h1000_0000+addr -> pc_out 0,4,8,12; if_id_pc 4,8,12; if_id_instruction 32'h1000_0000, 32'h1000_0004, 32'h1000_0008; if_id_valid=1 from first post-reset edge.
- freeze=1 for 3 cycles at pc_out=8 -> pc_out stays 8 and if_id holds {pc 8, instr 32'h1000_0004}; after release, next edge gives pc_out=12 and if_id_pc=12.
- branch_taken=1, branch_addr=32'h40 at pc_out=16 -> next edge pc_out=32'h40, if_id_valid=0, if_id_instruction=NOP; following edge if_id_pc=32'h44, valid=1.
- branch_taken=1 and freeze=1 together, branch_addr=32'h23 -> pc_out=32'h20 (aligned), IF/ID flushed, freeze ignored.
- Reset asserted during freeze with pc_out=12 -> next edge pc_out=0 and if_id_valid=0; pc wrap: load 32'hFFFF_FFFC via branch, one normal edge -> pc_out=0.
